// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : 2-read / 1-write register file with per-register pending
//                (scoreboard) bits and a registered pending-register count.
//                Combinational reads; out-of-range and hardwired-zero
//                addresses read 0 and are always ready.
//                Optional write-through bypass: define REGFILE_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int  DATA_W   = 32,
    parameter int  NUM_REGS = 32,
    parameter int  ADDR_W   = 5,
    parameter int  ZERO_REG = 1,
    localparam int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a_i,
    input  logic [ADDR_W-1:0] rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    output logic [DATA_W-1:0] rd_data_b_o,
    output logic              rd_ready_a_o,
    output logic              rd_ready_b_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    output logic [CNT_W-1:0]  pending_cnt_o
);

    // Index width of the storage arrays; addresses are range-checked before
    // being truncated to this width.
    localparam int              IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0] c_NUM_REGS = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;

    logic w_wr_ok;
    logic w_rsv_ok;
    logic w_set;
    logic w_clr;

    // True for addresses backed by a real, writable register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < c_NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    // Returns {ready, data} for one read port.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
        logic [DATA_W:0] res;
        res = {1'b1, {DATA_W{1'b0}}};
        if (addr_ok(a)) begin
`ifdef REGFILE_BYPASS_EN
            if (w_wr_ok && (wr_addr_i == a)) begin
                res = {1'b1, wr_data_i};
            end else begin
                res = {~pending_q[idx(a)], regs_q[idx(a)]};
            end
`else
            res = {~pending_q[idx(a)], regs_q[idx(a)]};
`endif
        end
        return res;
    endfunction

    // Write is gated by rst_n so a write in a reset cycle never bypasses.
    assign w_wr_ok  = rst_n && wr_en_i && addr_ok(wr_addr_i);
    assign w_rsv_ok = rsv_en_i && addr_ok(rsv_addr_i);

    // Read port A: combinational lookup.
    always_comb begin
        {rd_ready_a_o, rd_data_a_o} = lookup(rd_addr_a_i);
    end

    // Read port B: combinational lookup.
    always_comb begin
        {rd_ready_b_o, rd_data_b_o} = lookup(rd_addr_b_i);
    end

    // Next pending vector and count delta; reserve overrides a same-register write.
    always_comb begin
        pending_d = pending_q;
        if (w_wr_ok) begin
            pending_d[idx(wr_addr_i)] = 1'b0;
        end
        if (w_rsv_ok) begin
            pending_d[idx(rsv_addr_i)] = 1'b1;
        end
        w_set = w_rsv_ok && !pending_q[idx(rsv_addr_i)];
        w_clr = w_wr_ok && pending_q[idx(wr_addr_i)]
                && !(w_rsv_ok && (rsv_addr_i == wr_addr_i));
        cnt_d = cnt_q + CNT_W'(w_set) - CNT_W'(w_clr);
    end

    // Register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_ok) begin
            regs_q[idx(wr_addr_i)] <= wr_data_i;
        end
    end

    // Scoreboard bits and their running population count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_cnt_o = cnt_q;

endmodule
`default_nettype wire
